// File: rtl/mux16_scan_serializer.sv
// Scan serializer for a 16:1 mux. It steps the mux select through codes 0..15,
// waits a settle time on each code, and packs the sampled bits into one word.
module mux16_scan_serializer #(
   parameter int SETTLE     = 1,
   parameter bit CONTINUOUS = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mux_in,
   output logic [3:0]  sel,
   output logic        busy,
   output logic [15:0] word,
   output logic        word_valid,
   input  logic        word_ready
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   logic [1:0]  r_state;
   logic [3:0]  r_sel;
   logic [3:0]  r_cnt;
   logic [15:0] r_shadow;
   logic [15:0] r_word;
   logic [15:0] w_captured;

   // Shadow with the bit being sampled this cycle merged in, so the final
   // sample reaches the word in the same edge that enters DONE.
   always_comb begin
      w_captured        = r_shadow;
      w_captured[r_sel] = mux_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_sel    <= 4'd0;
         r_cnt    <= 4'd0;
         r_shadow <= 16'h0000;
         r_word   <= 16'h0000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_SETTLE;
                  r_sel   <= 4'd0;
                  r_cnt   <= 4'd0;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == SETTLE_LAST) begin
                  r_state <= ST_SAMPLE;
                  r_cnt   <= 4'd0;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            ST_SAMPLE: begin
               r_shadow <= w_captured;
               if (r_sel != 4'd15) begin
                  r_sel   <= r_sel + 4'd1;
                  r_cnt   <= 4'd0;
                  r_state <= ST_SETTLE;
               end else begin
                  r_word  <= w_captured;
                  r_sel   <= 4'd0;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               // A handshake with a pending start chains straight into a new scan.
               if (word_ready) begin
                  if (CONTINUOUS || start) begin
                     r_state <= ST_SETTLE;
                     r_sel   <= 4'd0;
                     r_cnt   <= 4'd0;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign sel        = r_sel;
   assign busy       = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
   assign word       = r_word;
   assign word_valid = (r_state == ST_DONE);

endmodule

// File: tb/tb_mux16_scan_serializer.sv
// Bench for mux16_scan_serializer: three instances (SETTLE=1, SETTLE=3, continuous)
// fed by a pattern-driven mux model and checked against arithmetic expectations.
module tb_mux16_scan_serializer;

   logic        clk;
   logic        rst_n;
   logic        startS [3];
   logic        readyS [3];
   logic        muxS   [3];
   logic        busyS  [3];
   logic        validS [3];
   logic [3:0]  selS   [3];
   logic [15:0] wordS  [3];
   logic [15:0] patS   [3];

   int passCount;
   int checkCount;

   logic [3:0] selQ  [$];
   logic       busyQ [$];

   mux16_scan_serializer #(.SETTLE(1), .CONTINUOUS(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(startS[0]), .mux_in(muxS[0]), .sel(selS[0]),
      .busy(busyS[0]), .word(wordS[0]), .word_valid(validS[0]), .word_ready(readyS[0]));

   mux16_scan_serializer #(.SETTLE(3), .CONTINUOUS(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(startS[1]), .mux_in(muxS[1]), .sel(selS[1]),
      .busy(busyS[1]), .word(wordS[1]), .word_valid(validS[1]), .word_ready(readyS[1]));

   mux16_scan_serializer #(.SETTLE(1), .CONTINUOUS(1'b1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(startS[2]), .mux_in(muxS[2]), .sel(selS[2]),
      .busy(busyS[2]), .word(wordS[2]), .word_valid(validS[2]), .word_ready(readyS[2]));

   // The mux model: the serial input is simply the pattern bit addressed by sel.
   assign muxS[0] = patS[0][selS[0]];
   assign muxS[1] = patS[1][selS[1]];
   assign muxS[2] = patS[2][selS[2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int settleOf(input int d);
      return (d == 1) ? 3 : 1;
   endfunction

   // Issues start (optionally with ready, for a DONE-chained scan), then records
   // sel/busy every cycle until word_valid, bounded by a cycle budget.
   task automatic run_scan(input int d, input bit withReady, output int lat, output logic [15:0] w);
      startS[d] = 1'b1;
      if (withReady) readyS[d] = 1'b1;
      @(negedge clk);
      startS[d] = 1'b0;
      readyS[d] = 1'b0;
      lat = 0;
      selQ.delete();
      busyQ.delete();
      while (!validS[d] && lat < 300) begin
         selQ.push_back(selS[d]);
         busyQ.push_back(busyS[d]);
         @(negedge clk);
         lat++;
      end
      w = wordS[d];
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checkCount++;
         if (selS[d] !== 4'd0) $display("[TB] FAIL reset_sel dut%0d got %0d want 0", d, selS[d]);
         else passCount++;
         checkCount++;
         if (busyS[d] !== 1'b0) $display("[TB] FAIL reset_busy dut%0d got %b want 0", d, busyS[d]);
         else passCount++;
         checkCount++;
         if (validS[d] !== 1'b0) $display("[TB] FAIL reset_valid dut%0d got %b want 0", d, validS[d]);
         else passCount++;
         checkCount++;
         if (wordS[d] !== 16'h0000) $display("[TB] FAIL reset_word dut%0d got %h want 0000", d, wordS[d]);
         else passCount++;
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_scan(input int d, input logic [15:0] pat, input bit withReady);
      int          lat;
      int          bad;
      int          s;
      logic [15:0] w;
      s = settleOf(d);
      patS[d] = pat;
      run_scan(d, withReady, lat, w);
      checkCount++;
      if (lat !== 16 * (s + 1)) $display("[TB] FAIL scan_latency dut%0d got %0d want %0d", d, lat, 16 * (s + 1));
      else passCount++;
      checkCount++;
      if (w !== pat) $display("[TB] FAIL scan_word dut%0d got %h want %h", d, w, pat);
      else passCount++;
      bad = 0;
      for (int c = 0; c < selQ.size(); c++)
         if (selQ[c] !== 4'(c / (s + 1)) || busyQ[c] !== 1'b1) bad++;
      checkCount++;
      if (bad !== 0) $display("[TB] FAIL sel_trace dut%0d got %0d bad cycles want 0", d, bad);
      else passCount++;
      checkCount++;
      if (selS[d] !== 4'd0 || busyS[d] !== 1'b0) $display("[TB] FAIL done_outputs dut%0d got sel=%0d busy=%b want 0/0", d, selS[d], busyS[d]);
      else passCount++;
   endtask

   task automatic handshake_to_idle(input int d, input logic [15:0] pat);
      readyS[d] = 1'b1;
      @(negedge clk);
      readyS[d] = 1'b0;
      checkCount++;
      if (validS[d] !== 1'b0 || busyS[d] !== 1'b0) $display("[TB] FAIL idle_after_ack dut%0d got valid=%b busy=%b want 0/0", d, validS[d], busyS[d]);
      else passCount++;
      checkCount++;
      if (wordS[d] !== pat) $display("[TB] FAIL word_held_idle dut%0d got %h want %h", d, wordS[d], pat);
      else passCount++;
   endtask

   task automatic test_basic_scan;
      logic [15:0] pat;
      for (int i = 0; i < 5; i++) begin
         pat = (i == 0) ? 16'hA5C3 : 16'($urandom);
         test_scan(0, pat, 1'b0);
         handshake_to_idle(0, pat);
      end
   endtask

   task automatic test_reset_midscan;
      int n;
      int busyCycles;
      patS[0] = 16'($urandom);
      startS[0] = 1'b1;
      @(negedge clk);
      startS[0] = 1'b0;
      n = 0;
      while (selS[0] !== 4'd7 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checkCount++;
      if (selS[0] !== 4'd7) $display("[TB] FAIL reach_sel7 got %0d want 7", selS[0]);
      else passCount++;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkCount++;
      if (selS[0] !== 4'd0 || busyS[0] !== 1'b0 || validS[0] !== 1'b0 || wordS[0] !== 16'h0000)
         $display("[TB] FAIL midscan_reset got sel=%0d busy=%b valid=%b word=%h want 0/0/0/0000",
                  selS[0], busyS[0], validS[0], wordS[0]);
      else passCount++;
      rst_n = 1'b1;
      busyCycles = 0;
      repeat (20) begin
         @(negedge clk);
         if (busyS[0] || validS[0]) busyCycles++;
      end
      checkCount++;
      if (busyCycles !== 0) $display("[TB] FAIL no_resume_after_reset got %0d active cycles want 0", busyCycles);
      else passCount++;
      test_scan(0, 16'h1234, 1'b0);
      handshake_to_idle(0, 16'h1234);
   endtask

   task automatic test_backpressure;
      logic [15:0] pat;
      int          bad;
      pat = 16'($urandom);
      test_scan(0, pat, 1'b0);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (validS[0] !== 1'b1 || wordS[0] !== pat || selS[0] !== 4'd0) bad++;
      end
      checkCount++;
      if (bad !== 0) $display("[TB] FAIL hold_under_backpressure got %0d bad cycles want 0", bad);
      else passCount++;
      handshake_to_idle(0, pat);
   endtask

   task automatic test_start_ignored;
      logic [15:0] pat;
      int          lat;
      int          active;
      bit          pulsed;
      pat = 16'($urandom);
      patS[0] = pat;
      startS[0] = 1'b1;
      @(negedge clk);
      startS[0] = 1'b0;
      lat = 0;
      pulsed = 1'b0;
      while (!validS[0] && lat < 300) begin
         if (selS[0] === 4'd4 && !pulsed) begin
            startS[0] = 1'b1;
            pulsed = 1'b1;
         end else begin
            startS[0] = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      startS[0] = 1'b0;
      checkCount++;
      if (lat !== 32 || wordS[0] !== pat) $display("[TB] FAIL start_ignored_scan got lat=%0d word=%h want 32/%h", lat, wordS[0], pat);
      else passCount++;
      handshake_to_idle(0, pat);
      active = 0;
      repeat (40) begin
         @(negedge clk);
         if (busyS[0] || validS[0]) active++;
      end
      checkCount++;
      if (active !== 0) $display("[TB] FAIL no_queued_scan got %0d active cycles want 0", active);
      else passCount++;
   endtask

   task automatic test_back_to_back;
      logic [15:0] p1;
      logic [15:0] p2;
      p1 = 16'($urandom);
      p2 = ~p1;
      test_scan(0, p1, 1'b0);
      test_scan(0, p2, 1'b1);
      handshake_to_idle(0, p2);
   endtask

   task automatic test_settle3;
      logic [15:0] pat;
      for (int i = 0; i < 3; i++) begin
         pat = (i == 0) ? 16'h8001 : 16'($urandom);
         test_scan(1, pat, 1'b0);
         handshake_to_idle(1, pat);
      end
   endtask

   task automatic test_continuous;
      int          lat;
      logic [15:0] next;
      readyS[2] = 1'b1;
      patS[2] = 16'hFFFF;
      startS[2] = 1'b1;
      @(negedge clk);
      startS[2] = 1'b0;
      lat = 0;
      while (!validS[2] && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      checkCount++;
      if (lat !== 32 || wordS[2] !== 16'hFFFF) $display("[TB] FAIL cont_first got lat=%0d word=%h want 32/ffff", lat, wordS[2]);
      else passCount++;
      for (int i = 0; i < 2; i++) begin
         next = (i == 0) ? 16'h0001 : 16'($urandom);
         patS[2] = next;
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!validS[2] && lat < 300);
         checkCount++;
         if (lat !== 33 || wordS[2] !== next) $display("[TB] FAIL cont_gap%0d got gap=%0d word=%h want 33/%h", i, lat, wordS[2], next);
         else passCount++;
      end
      readyS[2] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      passCount  = 0;
      checkCount = 0;
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         startS[d] = 1'b0;
         readyS[d] = 1'b0;
         patS[d]   = 16'h0000;
      end
      test_reset;
      test_basic_scan;
      test_reset_midscan;
      test_backpressure;
      test_start_ignored;
      test_back_to_back;
      test_settle3;
      test_continuous;
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mux16_scan_serializer.md
MUX16_SCAN_SERIALIZER -- requirements
Module: mux16_scan_serializer

Interface
REQ-001 Parameter: SETTLE, default 1, wait cycles after each sel change before sampling (legal range 1..15).
REQ-002 Parameter: CONTINUOUS, default 0, 1 = restart a new scan automatically after each word handshake.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request one scan; sampled only in IDLE, or in DONE together with word_ready.
REQ-006 mux_in  input  1  serial data from the 16:1 mux output.
REQ-007 sel  output  4  select code driven to the 16:1 mux.
REQ-008 busy  output  1  high while in SETTLE or SAMPLE.
REQ-009 word  output  16  assembled word; bit i = mux_in sampled while sel == i.
REQ-010 word_valid  output  1  word available; high only in DONE.
REQ-011 word_ready  input  1  consumer accepts word when high with word_valid.

Function
REQ-012 The block shall implement four states: IDLE, SETTLE, SAMPLE, DONE.
REQ-013 IDLE: sel = 0, busy = 0, word_valid = 0; start = 1 -> SETTLE with sel = 0 and settle counter = 0.
REQ-014 SETTLE: counter increments each cycle; after exactly SETTLE cycles in SETTLE -> SAMPLE; sel held constant.
REQ-015 SAMPLE: one cycle; mux_in captured into shadow bit [sel]; if sel != 15 -> sel + 1, counter cleared, -> SETTLE; if sel == 15 -> DONE.
REQ-016 On entry to DONE, word shall load the full shadow including the bit captured in that SAMPLE cycle; sel returns to 0.
REQ-017 word shall change only on entry to DONE; it is held stable at all other times, including while word_valid waits on word_ready.
REQ-018 Latency: start accepted at edge k -> word_valid high after edge k + 16*(SETTLE+1); 32 cycles for SETTLE = 1.
REQ-019 DONE with word_ready = 0: remain in DONE, word_valid = 1, word and sel stable.
REQ-020 DONE with word_ready = 1: if CONTINUOUS = 1 or start = 1 -> SETTLE (sel = 0, new scan); otherwise -> IDLE.
REQ-021 start while in SETTLE or SAMPLE shall be ignored; no queuing of requests.
REQ-022 sel increments by exactly 1 per SAMPLE, never wraps within a scan, and never exceeds 15.
REQ-023 Shadow bits are overwritten on every scan; no stale bits from a previous scan may reach word.

Reset
REQ-024 While rst_n = 0 at a clock edge: state = IDLE, sel = 0, busy = 0, word_valid = 0, word = 16'h0000, shadow = 0, counter = 0.
REQ-025 Reset mid-scan or in DONE shall abort immediately with no partial word presented; the first start after release begins a full scan from sel = 0.

Verification
REQ-026 Mux model pattern 16'hA5C3, SETTLE = 1, single start pulse -> sel steps 0..15, each held 2 cycles; word_valid high 32 cycles after start; word = 16'hA5C3.
REQ-027 rst_n low for 2 cycles while sel = 7 -> sel = 0, busy = 0, word_valid = 0, word = 16'h0000; a following scan of 16'h1234 returns 16'h1234.
REQ-028 word_ready held low 10 cycles after word_valid -> word_valid stays 1 and word stays constant for all 10 cycles; ready = 1 -> IDLE on the next cycle.
REQ-029 start pulsed at sel = 4 during an active scan -> ignored; exactly one word produced; busy low after the handshake.
REQ-030 CONTINUOUS = 1, word_ready tied high, pattern changed 16'hFFFF -> 16'h0001 between scans -> consecutive word_valid pulses 33 cycles apart with words 16'hFFFF then 16'h0001.
REQ-031 SETTLE = 3, pattern 16'h8001 -> each sel held 4 cycles; word_valid 64 cycles after start; word = 16'h8001.
